// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// The master issues one request and holds it until ready; load data returns with rvalid.
interface mem_stage_if;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_mask_out;
    logic        dmem_ready_in;
    logic        dmem_rvalid_in;
    logic [31:0] dmem_rdata_in;

    modport master (
        output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out,
        input  dmem_ready_in, dmem_rvalid_in, dmem_rdata_in
    );

    modport slave (
        input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out,
        output dmem_ready_in, dmem_rvalid_in, dmem_rdata_in
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through, issues aligned loads/stores on the
// data-memory bus, formats load data by size/sign, and flags misalignment and response timeouts.
module mem_stage #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [7:0]  mem_mask_in,
    input  logic [31:0] alu_result_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    mem_stage_if.master dmem,
    output logic        stall_out,
    output logic        wb_valid_out,
    output logic        wb_we_out,
    output logic [4:0]  wb_rd_out,
    output logic [31:0] wb_data_out,
    output logic        misalign_out,
    output logic        timeout_out
);
    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             timeout_hit;
    logic [4:0]       rd_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [1:0]       off;
    logic             is_mem;
    logic             misaligned;
    logic [31:0]      shifted;
    logic [31:0]      load_data;
    logic             unused_mask_hi;

    assign unused_mask_hi = ^mem_mask_in[7:4];

    always_comb begin
        off        = mem_addr_in[1:0];
        is_mem     = mem_read_in | mem_write_in;
        misaligned = 1'b0;
        case (funct3_in)
            3'd1, 3'd5: misaligned = off[0];
            3'd2:       misaligned = (off != 2'd0);
            default:    misaligned = 1'b0;
        endcase
    end

    // Funct3 codes outside the defined load sizes fall through to a full-word load.
    always_comb begin
        shifted   = dmem.dmem_rdata_in >> {off_q, 3'b000};
        load_data = shifted;
        case (funct3_q)
            3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_data = {24'd0, shifted[7:0]};
            3'd5:    load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign wait_cnt_next = wait_cnt + CNT_W'(1);
    assign timeout_hit   = (wait_cnt_next == CNT_W'(RESP_TIMEOUT));

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            wait_cnt            <= '0;
            rd_q                <= '0;
            funct3_q            <= '0;
            off_q               <= '0;
            stall_out           <= 1'b0;
            wb_valid_out        <= 1'b0;
            wb_we_out           <= 1'b0;
            wb_rd_out           <= '0;
            wb_data_out         <= '0;
            misalign_out        <= 1'b0;
            timeout_out         <= 1'b0;
            dmem.dmem_req_out   <= 1'b0;
            dmem.dmem_we_out    <= 1'b0;
            dmem.dmem_addr_out  <= '0;
            dmem.dmem_wdata_out <= '0;
            dmem.dmem_mask_out  <= '0;
        end else begin
            // Writeback and error outputs are single-cycle pulses unless re-asserted below.
            wb_valid_out <= 1'b0;
            wb_we_out    <= 1'b0;
            wb_rd_out    <= '0;
            wb_data_out  <= '0;
            misalign_out <= 1'b0;
            timeout_out  <= 1'b0;

            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (!is_mem) begin
                            wb_valid_out <= 1'b1;
                            wb_we_out    <= (rd_in != 5'd0);
                            wb_rd_out    <= rd_in;
                            wb_data_out  <= alu_result_in;
                        end else if (misaligned) begin
                            misalign_out <= 1'b1;
                            wb_valid_out <= 1'b1;
                            wb_rd_out    <= rd_in;
                        end else begin
                            state               <= REQ;
                            stall_out           <= 1'b1;
                            rd_q                <= rd_in;
                            funct3_q            <= funct3_in;
                            off_q               <= off;
                            dmem.dmem_req_out   <= 1'b1;
                            dmem.dmem_we_out    <= mem_write_in;
                            dmem.dmem_addr_out  <= {mem_addr_in[31:2], 2'b00};
                            dmem.dmem_mask_out  <= mem_mask_in[3:0] << off;
                            dmem.dmem_wdata_out <= mem_wdata_in << {off, 3'b000};
                        end
                    end
                end

                REQ: begin
                    if (dmem.dmem_ready_in) begin
                        dmem.dmem_req_out   <= 1'b0;
                        dmem.dmem_we_out    <= 1'b0;
                        dmem.dmem_addr_out  <= '0;
                        dmem.dmem_wdata_out <= '0;
                        dmem.dmem_mask_out  <= '0;
                        if (dmem.dmem_we_out) begin
                            state        <= IDLE;
                            stall_out    <= 1'b0;
                            wb_valid_out <= 1'b1;
                            wb_rd_out    <= rd_q;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end

                WAIT: begin
                    if (dmem.dmem_rvalid_in) begin
                        state        <= IDLE;
                        stall_out    <= 1'b0;
                        wb_valid_out <= 1'b1;
                        wb_we_out    <= (rd_q != 5'd0);
                        wb_rd_out    <= rd_q;
                        wb_data_out  <= load_data;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                        if (timeout_hit) begin
                            state        <= IDLE;
                            stall_out    <= 1'b0;
                            timeout_out  <= 1'b1;
                            wb_valid_out <= 1'b1;
                            wb_rd_out    <= rd_q;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    stall_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage; expected values come from a size/sign
// model written with plain arithmetic on the access address and the returned word.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic [7:0]  mem_mask_in;
    logic [31:0] alu_result_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic        stall_out;
    logic        wb_valid_out;
    logic        wb_we_out;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out;
    logic        misalign_out;
    logic        timeout_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_if dmem_bus ();

    mem_stage #(.RESP_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .mem_addr_in  (mem_addr_in),
        .mem_wdata_in (mem_wdata_in),
        .mem_mask_in  (mem_mask_in),
        .alu_result_in(alu_result_in),
        .funct3_in    (funct3_in),
        .rd_in        (rd_in),
        .dmem         (dmem_bus.master),
        .stall_out    (stall_out),
        .wb_valid_out (wb_valid_out),
        .wb_we_out    (wb_we_out),
        .wb_rd_out    (wb_rd_out),
        .wb_data_out  (wb_data_out),
        .misalign_out (misalign_out),
        .timeout_out  (timeout_out)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] s;
        logic [31:0] v;
        s = rdata / (32'd1 << (8 * (addr % 4)));
        case (f3)
            3'd0: begin v = s % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = s % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = s % 256;
            3'd5: v = s % 65536;
            default: v = s;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] pick_addr(input logic [2:0] f3);
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        if (f3 == 3'd0 || f3 == 3'd4) return base + ($urandom % 4);
        if (f3 == 3'd1 || f3 == 3'd5) return base + 2 * ($urandom % 2);
        return base;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; mem_read_in = 0; mem_write_in = 0;
        mem_addr_in = 0; mem_wdata_in = 0; mem_mask_in = 0;
        alu_result_in = 0; funct3_in = 0; rd_in = 0;
        dmem_bus.dmem_ready_in = 0; dmem_bus.dmem_rvalid_in = 0; dmem_bus.dmem_rdata_in = 0;
    endtask

    task automatic do_alu(input logic [31:0] alu, input logic [4:0] rd);
        valid_in = 1; mem_read_in = 0; mem_write_in = 0;
        alu_result_in = alu; rd_in = rd; funct3_in = 3'($urandom);
        step();
        valid_in = 0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [4:0] rd, input int rdly, input int vdly,
                           output logic v, output logic we, output logic to,
                           output logic [4:0] rdo, output logic [31:0] data);
        valid_in = 1; mem_read_in = 1; mem_write_in = 0;
        funct3_in = f3; mem_addr_in = addr; rd_in = rd;
        mem_mask_in = 8'h0F; mem_wdata_in = $urandom;
        step();
        valid_in = 0; mem_read_in = 0;
        checks++;
        if (dmem_bus.dmem_req_out !== 1'b1 || dmem_bus.dmem_we_out !== 1'b0 ||
            dmem_bus.dmem_addr_out !== (addr & 32'hFFFF_FFFC) || stall_out !== 1'b1) begin
            errors++;
            $display("FAIL load_req: req=%b we=%b addr=%h stall=%b expected req=1 we=0 addr=%h stall=1",
                     dmem_bus.dmem_req_out, dmem_bus.dmem_we_out, dmem_bus.dmem_addr_out, stall_out,
                     addr & 32'hFFFF_FFFC);
        end
        repeat (rdly) step();
        // A stray rvalid in the acceptance cycle must not complete the load.
        dmem_bus.dmem_ready_in = 1; dmem_bus.dmem_rvalid_in = 1; dmem_bus.dmem_rdata_in = ~rdata;
        step();
        dmem_bus.dmem_ready_in = 0; dmem_bus.dmem_rvalid_in = 0;
        checks++;
        if (wb_valid_out !== 1'b0 || stall_out !== 1'b1 || dmem_bus.dmem_req_out !== 1'b0) begin
            errors++;
            $display("FAIL load_accept: wb_valid=%b stall=%b req=%b expected 0,1,0",
                     wb_valid_out, stall_out, dmem_bus.dmem_req_out);
        end
        repeat (vdly) step();
        dmem_bus.dmem_rvalid_in = 1; dmem_bus.dmem_rdata_in = rdata;
        step();
        dmem_bus.dmem_rvalid_in = 0;
        v = wb_valid_out; we = wb_we_out; to = timeout_out; rdo = wb_rd_out; data = wb_data_out;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] mask, input logic [4:0] rd, input int rdly,
                            input logic both, output logic v, output logic we, output logic st);
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        e_addr  = addr & 32'hFFFF_FFFC;
        e_wdata = wdata * (32'd1 << (8 * (addr % 4)));
        e_mask  = 4'(((mask % 16) * (1 << (addr % 4))) % 16);
        valid_in = 1; mem_read_in = both; mem_write_in = 1;
        funct3_in = f3; mem_addr_in = addr; mem_wdata_in = wdata; mem_mask_in = mask; rd_in = rd;
        step();
        valid_in = 0; mem_read_in = 0; mem_write_in = 0;
        for (int i = 0; i <= rdly; i++) begin
            if (i > 0) step();
            checks++;
            if (dmem_bus.dmem_req_out !== 1'b1 || dmem_bus.dmem_we_out !== 1'b1 ||
                dmem_bus.dmem_addr_out !== e_addr || dmem_bus.dmem_mask_out !== e_mask ||
                dmem_bus.dmem_wdata_out !== e_wdata || stall_out !== 1'b1) begin
                errors++;
                $display("FAIL store_req[%0d]: req=%b we=%b addr=%h mask=%h wdata=%h stall=%b expected 1 1 %h %h %h 1",
                         i, dmem_bus.dmem_req_out, dmem_bus.dmem_we_out, dmem_bus.dmem_addr_out,
                         dmem_bus.dmem_mask_out, dmem_bus.dmem_wdata_out, stall_out,
                         e_addr, e_mask, e_wdata);
            end
        end
        dmem_bus.dmem_ready_in = 1;
        step();
        dmem_bus.dmem_ready_in = 0;
        v = wb_valid_out; we = wb_we_out; st = stall_out;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        checks++;
        if ({stall_out, wb_valid_out, wb_we_out, misalign_out, timeout_out,
             dmem_bus.dmem_req_out, dmem_bus.dmem_we_out} !== 7'b0 ||
            wb_data_out !== 32'd0 || wb_rd_out !== 5'd0 || dmem_bus.dmem_addr_out !== 32'd0 ||
            dmem_bus.dmem_mask_out !== 4'd0 || dmem_bus.dmem_wdata_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b wb_valid=%b wb_data=%h req=%b expected all zero",
                     stall_out, wb_valid_out, wb_data_out, dmem_bus.dmem_req_out);
        end
        reset = 0;
        step();
        checks++;
        if (wb_valid_out !== 1'b0 || misalign_out !== 1'b0 || timeout_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_valid: wb_valid=%b misalign=%b timeout=%b expected 0 0 0",
                     wb_valid_out, misalign_out, timeout_out);
        end
    endtask

    task automatic test_alu();
        logic [31:0] a;
        logic [4:0]  r;
        do_alu(32'h1234, 5'd5);
        checks++;
        if (wb_valid_out !== 1 || wb_we_out !== 1 || wb_data_out !== 32'h1234 ||
            wb_rd_out !== 5'd5 || stall_out !== 0) begin
            errors++;
            $display("FAIL alu_rd5: v=%b we=%b data=%h rd=%0d stall=%b expected 1 1 00001234 5 0",
                     wb_valid_out, wb_we_out, wb_data_out, wb_rd_out, stall_out);
        end
        step();
        checks++;
        if (wb_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL alu_pulse: wb_valid=%b expected 0", wb_valid_out);
        end
        do_alu(32'h1234, 5'd0);
        checks++;
        if (wb_valid_out !== 1 || wb_we_out !== 0 || wb_data_out !== 32'h1234) begin
            errors++;
            $display("FAIL alu_rd0: v=%b we=%b data=%h expected 1 0 00001234",
                     wb_valid_out, wb_we_out, wb_data_out);
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom; r = 5'($urandom);
            do_alu(a, r);
            checks++;
            if (wb_valid_out !== 1 || wb_we_out !== (r != 0) || wb_data_out !== a || wb_rd_out !== r) begin
                errors++;
                $display("FAIL alu_rand[%0d]: v=%b we=%b data=%h rd=%0d expected 1 %b %h %0d",
                         i, wb_valid_out, wb_we_out, wb_data_out, wb_rd_out, r != 0, a, r);
            end
        end
        step();
    endtask

    task automatic test_store_stall();
        logic v, we, st;
        do_store(3'd0, 32'h103, 32'hAB, 8'h01, 5'd3, 3, 1'b0, v, we, st);
        checks++;
        if (v !== 1 || we !== 0 || st !== 0 || dmem_bus.dmem_req_out !== 0) begin
            errors++;
            $display("FAIL sb_done: v=%b we=%b stall=%b req=%b expected 1 0 0 0",
                     v, we, st, dmem_bus.dmem_req_out);
        end
        step();
        checks++;
        if (wb_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL sb_pulse: wb_valid=%b expected 0", wb_valid_out);
        end
    endtask

    task automatic test_load_extend();
        logic v, we, to;
        logic [4:0] r;
        logic [31:0] d;
        do_load(3'd0, 32'h102, 32'h0080_0000, 5'd4, 0, 0, v, we, to, r, d);
        checks++;
        if (v !== 1 || we !== 1 || r !== 5'd4 || d !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_sign: v=%b we=%b rd=%0d data=%h expected 1 1 4 ffffff80", v, we, r, d);
        end
        do_load(3'd4, 32'h102, 32'h0080_0000, 5'd4, 1, 1, v, we, to, r, d);
        checks++;
        if (v !== 1 || d !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_zero: v=%b data=%h expected 1 00000080", v, d);
        end
        do_load(3'd1, 32'h202, 32'h8001_7F00, 5'd0, 0, 2, v, we, to, r, d);
        checks++;
        if (v !== 1 || we !== 0 || d !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_rd0: v=%b we=%b data=%h expected 1 0 ffff8001", v, we, d);
        end
    endtask

    task automatic test_load_random();
        logic v, we, to;
        logic [4:0]  r, rd;
        logic [31:0] d, a, rdata;
        logic [2:0]  f3;
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom); a = pick_addr(f3); rdata = $urandom; rd = 5'($urandom);
            do_load(f3, a, rdata, rd, int'($urandom % 3), int'($urandom % 4), v, we, to, r, d);
            checks++;
            if (v !== 1 || to !== 0 || we !== (rd != 0) || r !== rd || d !== model_load(f3, a, rdata)) begin
                errors++;
                $display("FAIL load_rand[%0d] f3=%0d addr=%h: v=%b to=%b we=%b rd=%0d data=%h expected 1 0 %b %0d %h",
                         i, f3, a, v, to, we, r, d, rd != 0, rd, model_load(f3, a, rdata));
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd5, 3'd2};
        logic [31:0] adrs[4] = '{32'h101, 32'h203, 32'h001, 32'h302};
        logic        wrs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            valid_in = 1; mem_read_in = !wrs[i]; mem_write_in = wrs[i];
            funct3_in = f3s[i]; mem_addr_in = adrs[i]; rd_in = 5'd6; mem_mask_in = 8'h0F;
            step();
            valid_in = 0; mem_read_in = 0; mem_write_in = 0;
            checks++;
            if (misalign_out !== 1 || wb_valid_out !== 1 || wb_we_out !== 0 ||
                dmem_bus.dmem_req_out !== 0 || stall_out !== 0) begin
                errors++;
                $display("FAIL misalign[%0d]: mis=%b v=%b we=%b req=%b stall=%b expected 1 1 0 0 0",
                         i, misalign_out, wb_valid_out, wb_we_out, dmem_bus.dmem_req_out, stall_out);
            end
            step();
            checks++;
            if (misalign_out !== 0 || wb_valid_out !== 0 || dmem_bus.dmem_req_out !== 0) begin
                errors++;
                $display("FAIL misalign_pulse[%0d]: mis=%b v=%b req=%b expected 0 0 0",
                         i, misalign_out, wb_valid_out, dmem_bus.dmem_req_out);
            end
        end
    endtask

    task automatic test_timeout();
        valid_in = 1; mem_read_in = 1; funct3_in = 3'd2; mem_addr_in = 32'h200; rd_in = 5'd7;
        step();
        valid_in = 0; mem_read_in = 0;
        dmem_bus.dmem_ready_in = 1;
        step();
        dmem_bus.dmem_ready_in = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (timeout_out !== 0 || stall_out !== 1 || wb_valid_out !== 0) begin
                errors++;
                $display("FAIL timeout_early[%0d]: to=%b stall=%b v=%b expected 0 1 0",
                         i, timeout_out, stall_out, wb_valid_out);
            end
        end
        step();
        checks++;
        if (timeout_out !== 1 || wb_valid_out !== 1 || wb_we_out !== 0 ||
            wb_data_out !== 32'd0 || stall_out !== 0) begin
            errors++;
            $display("FAIL timeout_fire: to=%b v=%b we=%b data=%h stall=%b expected 1 1 0 00000000 0",
                     timeout_out, wb_valid_out, wb_we_out, wb_data_out, stall_out);
        end
        dmem_bus.dmem_rvalid_in = 1; dmem_bus.dmem_rdata_in = 32'h1234_5678;
        step();
        dmem_bus.dmem_rvalid_in = 0;
        checks++;
        if (wb_valid_out !== 0 || timeout_out !== 0 || stall_out !== 0) begin
            errors++;
            $display("FAIL late_rvalid: v=%b to=%b stall=%b expected 0 0 0",
                     wb_valid_out, timeout_out, stall_out);
        end
    endtask

    task automatic test_rvalid_wins();
        logic v, we, to;
        logic [4:0]  r;
        logic [31:0] d, rdata;
        rdata = $urandom;
        do_load(3'd2, 32'h400, rdata, 5'd9, 0, 3, v, we, to, r, d);
        checks++;
        if (v !== 1 || to !== 0 || we !== 1 || d !== rdata) begin
            errors++;
            $display("FAIL rvalid_wins: v=%b to=%b we=%b data=%h expected 1 0 1 %h", v, to, we, d, rdata);
        end
    endtask

    task automatic test_read_write_store();
        logic v, we, st;
        do_store(3'd2, 32'h500, 32'hCAFE_F00D, 8'hFF, 5'd8, 1, 1'b1, v, we, st);
        checks++;
        if (v !== 1 || we !== 0 || st !== 0) begin
            errors++;
            $display("FAIL rw_as_store: v=%b we=%b stall=%b expected 1 0 0", v, we, st);
        end
    endtask

    task automatic test_reset_in_wait();
        valid_in = 1; mem_read_in = 1; funct3_in = 3'd2; mem_addr_in = 32'h600; rd_in = 5'd10;
        step();
        valid_in = 0; mem_read_in = 0;
        dmem_bus.dmem_ready_in = 1;
        step();
        dmem_bus.dmem_ready_in = 0;
        step();
        reset = 1;
        step();
        checks++;
        if (stall_out !== 0 || wb_valid_out !== 0 || dmem_bus.dmem_req_out !== 0 ||
            timeout_out !== 0 || misalign_out !== 0) begin
            errors++;
            $display("FAIL reset_wait: stall=%b v=%b req=%b to=%b mis=%b expected all 0",
                     stall_out, wb_valid_out, dmem_bus.dmem_req_out, timeout_out, misalign_out);
        end
        reset = 0;
        dmem_bus.dmem_rvalid_in = 1; dmem_bus.dmem_rdata_in = 32'hDEAD_BEEF;
        step();
        dmem_bus.dmem_rvalid_in = 0;
        checks++;
        if (wb_valid_out !== 0 || stall_out !== 0) begin
            errors++;
            $display("FAIL post_reset_rvalid: v=%b stall=%b expected 0 0", wb_valid_out, stall_out);
        end
    endtask

    task automatic test_back_to_back();
        logic v, we, to, st;
        logic [4:0]  r, rd;
        logic [31:0] d, a, x;
        logic [2:0]  f3;
        for (int i = 0; i < 20; i++) begin
            rd = 5'($urandom); x = $urandom;
            case ($urandom % 3)
                0: begin
                    do_alu(x, rd);
                    checks++;
                    if (wb_valid_out !== 1 || wb_data_out !== x || wb_we_out !== (rd != 0)) begin
                        errors++;
                        $display("FAIL b2b_alu[%0d]: v=%b data=%h we=%b expected 1 %h %b",
                                 i, wb_valid_out, wb_data_out, wb_we_out, x, rd != 0);
                    end
                end
                1: begin
                    f3 = 3'($urandom); a = pick_addr(f3);
                    do_load(f3, a, x, rd, int'($urandom % 2), int'($urandom % 3), v, we, to, r, d);
                    checks++;
                    if (v !== 1 || d !== model_load(f3, a, x) || we !== (rd != 0)) begin
                        errors++;
                        $display("FAIL b2b_load[%0d]: v=%b data=%h we=%b expected 1 %h %b",
                                 i, v, d, we, model_load(f3, a, x), rd != 0);
                    end
                end
                default: begin
                    f3 = 3'($urandom % 3); a = pick_addr(f3);
                    do_store(f3, a, x, 8'($urandom), rd, int'($urandom % 3), 1'b0, v, we, st);
                    checks++;
                    if (v !== 1 || we !== 0 || st !== 0) begin
                        errors++;
                        $display("FAIL b2b_store[%0d]: v=%b we=%b stall=%b expected 1 0 0", i, v, we, st);
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_stall();
        test_load_extend();
        test_load_random();
        test_misalign();
        test_timeout();
        test_rvalid_wins();
        test_read_write_store();
        test_reset_in_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
